// File: rtl/grid_sweeper_pkg.sv
// Shared types and constants for the grid sweeper: neighbour directions, sweep
// states and the per-cell schedule length.
package grid_sweeper_pkg;

    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_NE = 3'd1,
        DIR_E  = 3'd2,
        DIR_SE = 3'd3,
        DIR_S  = 3'd4,
        DIR_SW = 3'd5,
        DIR_W  = 3'd6,
        DIR_NW = 3'd7
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_PAUSED = 3'd4
    } sweep_state_e;

    typedef struct packed {
        logic x_dec;
        logic x_inc;
        logic y_dec;
        logic y_inc;
    } offset_t;

    localparam int DEF_GRID_W  = 160;
    localparam int DEF_GRID_H  = 120;
    localparam int CELL_CYCLES = 11;
    // FETCH k=0..8, then DRAIN and WRITE make up one cell
    localparam int FETCH_LAST  = CELL_CYCLES - 3;

    function automatic offset_t dir_offset(input dir_e dir);
        offset_t o;
        o = '0;
        case (dir)
            DIR_N:   o.y_dec = 1'b1;
            DIR_NE:  begin o.y_dec = 1'b1; o.x_inc = 1'b1; end
            DIR_E:   o.x_inc = 1'b1;
            DIR_SE:  begin o.y_inc = 1'b1; o.x_inc = 1'b1; end
            DIR_S:   o.y_inc = 1'b1;
            DIR_SW:  begin o.y_inc = 1'b1; o.x_dec = 1'b1; end
            DIR_W:   o.x_dec = 1'b1;
            DIR_NW:  begin o.y_dec = 1'b1; o.x_dec = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/grid_sweeper_neighbour_addr_gen.sv
// Combinational neighbour address generator: cell + direction -> lookup address,
// clamped to the centre cell when the neighbour falls outside the grid.
module neighbour_addr_gen
    import grid_sweeper_pkg::*;
#(
    parameter int X_bits = 8,
    parameter int Y_bits = 7,
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H
) (
    input  logic [X_bits-1:0] cell_x,
    input  logic [Y_bits-1:0] cell_y,
    input  logic              centre,
    input  dir_e              dir,
    output logic [X_bits-1:0] view_x,
    output logic [Y_bits-1:0] view_y,
    output logic              in_bounds
);

    localparam logic [X_bits:0] X_ONE = {{X_bits{1'b0}}, 1'b1};
    localparam logic [Y_bits:0] Y_ONE = {{Y_bits{1'b0}}, 1'b1};
    localparam logic [X_bits:0] X_LIM = (X_bits+1)'(GRID_W);
    localparam logic [Y_bits:0] Y_LIM = (Y_bits+1)'(GRID_H);

    offset_t         off_s;
    logic [X_bits:0] x_ext_s;
    logic [Y_bits:0] y_ext_s;
    logic            x_ok_s;
    logic            y_ok_s;

    // Offset with one guard bit; bounds decided before truncating back to coordinate width
    always_comb begin
        off_s   = centre ? '0 : dir_offset(dir);
        x_ext_s = {1'b0, cell_x};
        y_ext_s = {1'b0, cell_y};
        x_ok_s  = 1'b1;
        y_ok_s  = 1'b1;
        if (off_s.x_dec) begin
            x_ok_s  = (cell_x != '0);
            x_ext_s = {1'b0, cell_x} - X_ONE;
        end else if (off_s.x_inc) begin
            x_ext_s = {1'b0, cell_x} + X_ONE;
            x_ok_s  = (x_ext_s < X_LIM);
        end else begin
            x_ok_s  = 1'b1;
        end
        if (off_s.y_dec) begin
            y_ok_s  = (cell_y != '0);
            y_ext_s = {1'b0, cell_y} - Y_ONE;
        end else if (off_s.y_inc) begin
            y_ext_s = {1'b0, cell_y} + Y_ONE;
            y_ok_s  = (y_ext_s < Y_LIM);
        end else begin
            y_ok_s  = 1'b1;
        end
        in_bounds = x_ok_s & y_ok_s;
        view_x    = in_bounds ? x_ext_s[X_bits-1:0] : cell_x;
        view_y    = in_bounds ? y_ext_s[Y_bits-1:0] : cell_y;
    end

endmodule

// File: rtl/grid_sweeper.sv
// Per-tick raster sweeper: fetches each cell's 3x3 neighbourhood through the
// one-cycle-latency lookup port and strobes the assembled window out with write_flag.
module grid_sweeper
    import grid_sweeper_pkg::*;
#(
    parameter int X_bits      = 8,
    parameter int Y_bits      = 7,
    parameter int SIGNAL_bits = 4,
    parameter int GRID_W      = DEF_GRID_W,
    parameter int GRID_H      = DEF_GRID_H
) (
    input  logic                        newLocClock,
    input  logic                        RESET_SIM_N,
    input  logic                        RUN,
    input  logic                        PAUSE,
    input  logic                        game_tick,
    output logic [X_bits-1:0]           view_x,
    output logic [Y_bits-1:0]           view_y,
    input  logic [SIGNAL_bits-1:0]      view_signal,
    input  logic                        view_sugar,
    output logic [X_bits-1:0]           write_x,
    output logic [Y_bits-1:0]           write_y,
    output logic [7:0][SIGNAL_bits-1:0] surrounding_signals,
    output logic [SIGNAL_bits-1:0]      cur_signal,
    output logic                        cur_sugar,
    output logic                        write_flag,
    output logic                        sweep_busy,
    output logic                        sweep_done,
    output logic                        overrun
);

    localparam logic [X_bits-1:0] X_LAST   = X_bits'(GRID_W - 1);
    localparam logic [Y_bits-1:0] Y_LAST   = Y_bits'(GRID_H - 1);
    localparam logic [X_bits-1:0] X_STEP   = X_bits'(1'b1);
    localparam logic [Y_bits-1:0] Y_STEP   = Y_bits'(1'b1);
    localparam logic [3:0]        IDX_LAST = 4'(FETCH_LAST);

    sweep_state_e      state_r;
    sweep_state_e      next_state_s;
    logic [3:0]        idx_r;
    logic [3:0]        next_idx_s;
    logic [3:0]        idx_m1_s;
    logic [X_bits-1:0] next_x_s;
    logic [Y_bits-1:0] next_y_s;
    logic [X_bits-1:0] gen_x_s;
    logic [Y_bits-1:0] gen_y_s;
    logic              gen_inb_s;
    dir_e              gen_dir_s;
    logic              last_cell_s;
    logic              issue_inb_r;
    logic              prev_inb_r;
    logic              capture_s;
    logic [3:0]        slot_s;
    logic [3:0]        slot_m1_s;

    assign last_cell_s = (write_x == X_LAST) && (write_y == Y_LAST);

    // Next-state, fetch index and next-cell selection
    always_comb begin
        next_state_s = state_r;
        next_idx_s   = idx_r;
        next_x_s     = write_x;
        next_y_s     = write_y;
        case (state_r)
            ST_IDLE: begin
                if (game_tick) begin
                    next_state_s = ST_FETCH;
                    next_idx_s   = 4'd0;
                    next_x_s     = '0;
                    next_y_s     = '0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (idx_r == IDX_LAST) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_idx_s = idx_r + 4'd1;
                end
            end
            ST_DRAIN: next_state_s = ST_WRITE;
            ST_WRITE: begin
                if (last_cell_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    if (write_x == X_LAST) begin
                        next_x_s = '0;
                        next_y_s = write_y + Y_STEP;
                    end else begin
                        next_x_s = write_x + X_STEP;
                    end
                    next_idx_s   = 4'd0;
                    next_state_s = PAUSE ? ST_PAUSED : ST_FETCH;
                end
            end
            ST_PAUSED: begin
                if (!PAUSE) begin
                    next_state_s = ST_FETCH;
                    next_idx_s   = 4'd0;
                end else begin
                    next_state_s = ST_PAUSED;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
        if (!RUN) begin
            next_state_s = ST_IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // Fetch index k>0 addresses direction k-1; address is registered for the upcoming cycle
    always_comb begin
        idx_m1_s  = next_idx_s - 4'd1;
        gen_dir_s = dir_e'(idx_m1_s[2:0]);
    end

    neighbour_addr_gen #(
        .X_bits (X_bits),
        .Y_bits (Y_bits),
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_addr_gen (
        .cell_x    (next_x_s),
        .cell_y    (next_y_s),
        .centre    (next_idx_s == 4'd0),
        .dir       (gen_dir_s),
        .view_x    (gen_x_s),
        .view_y    (gen_y_s),
        .in_bounds (gen_inb_s)
    );

    // Slot whose data is on view_signal this cycle (addressed one cycle earlier)
    always_comb begin
        capture_s = 1'b0;
        slot_s    = 4'd0;
        if ((state_r == ST_FETCH) && (idx_r != 4'd0)) begin
            capture_s = 1'b1;
            slot_s    = idx_r - 4'd1;
        end else if (state_r == ST_DRAIN) begin
            capture_s = 1'b1;
            slot_s    = IDX_LAST;
        end else begin
            capture_s = 1'b0;
        end
        slot_m1_s = slot_s - 4'd1;
    end

    // Sequencer state, cell coordinates and status flags
    always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
        if (!RESET_SIM_N) begin
            state_r    <= ST_IDLE;
            idx_r      <= 4'd0;
            write_x    <= '0;
            write_y    <= '0;
            write_flag <= 1'b0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            idx_r      <= next_idx_s;
            write_x    <= next_x_s;
            write_y    <= next_y_s;
            write_flag <= (next_state_s == ST_WRITE);
            sweep_busy <= (next_state_s != ST_IDLE);
            sweep_done <= (state_r == ST_WRITE) && last_cell_s && RUN;
            overrun    <= overrun | (game_tick && (state_r != ST_IDLE));
        end
    end

    // Lookup address issue and window capture
    always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
        if (!RESET_SIM_N) begin
            view_x              <= '0;
            view_y              <= '0;
            issue_inb_r         <= 1'b0;
            prev_inb_r          <= 1'b0;
            surrounding_signals <= '0;
            cur_signal          <= '0;
            cur_sugar           <= 1'b0;
        end else begin
            if (next_state_s == ST_FETCH) begin
                view_x      <= gen_x_s;
                view_y      <= gen_y_s;
                issue_inb_r <= gen_inb_s;
            end else begin
                issue_inb_r <= issue_inb_r;
            end
            prev_inb_r <= issue_inb_r;
            if (capture_s && (slot_s == 4'd0)) begin
                cur_signal <= view_signal;
                cur_sugar  <= view_sugar;
            end else if (capture_s) begin
                surrounding_signals[slot_m1_s[2:0]] <= prev_inb_r ? view_signal : '0;
            end else begin
                cur_signal <= cur_signal;
            end
        end
    end

endmodule

// File: tb/tb_grid_sweeper.sv
// Self-checking bench for grid_sweeper on a 4x3 grid: scoreboard of expected cell
// writes plus a table of hand-derived windows and sequences for pause/abort/reset.
module tb_grid_sweeper;
    import grid_sweeper_pkg::*;

    localparam int GW = 4;
    localparam int GH = 3;
    localparam int NC = GW * GH;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       run   = 1'b0;
    logic       pause = 1'b0;
    logic       tick  = 1'b0;
    logic [7:0] view_x, write_x;
    logic [6:0] view_y, write_y;
    logic [3:0] view_signal = 4'd0;
    logic       view_sugar  = 1'b0;
    logic [3:0] cur_signal;
    logic       cur_sugar, write_flag, sweep_busy, sweep_done, overrun;
    logic [7:0][3:0] surr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c0      = 0;
    int wr_cnt  = 0;
    int exp_done_at = -1;
    int sweep_id = 0;
    int wr_mark;

    logic [3:0] sig_mem [NC];
    logic       sug_mem [NC];

    typedef struct {
        int         x;
        int         y;
        logic [3:0] cur;
        logic       sug;
        logic [31:0] win;
        int         at;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        int          sw;
        int          x;
        int          y;
        logic [3:0]  cur;
        logic [31:0] win;
    } vec_t;
    vec_t vt[7];

    logic [3:0]  seen_cur [2][NC];
    logic [31:0] seen_win [2][NC];

    grid_sweeper #(
        .X_bits(8), .Y_bits(7), .SIGNAL_bits(4), .GRID_W(GW), .GRID_H(GH)
    ) dut (
        .newLocClock         (clk),
        .RESET_SIM_N         (rst_n),
        .RUN                 (run),
        .PAUSE               (pause),
        .game_tick           (tick),
        .view_x              (view_x),
        .view_y              (view_y),
        .view_signal         (view_signal),
        .view_sugar          (view_sugar),
        .write_x             (write_x),
        .write_y             (write_y),
        .surrounding_signals (surr),
        .cur_signal          (cur_signal),
        .cur_sugar           (cur_sugar),
        .write_flag          (write_flag),
        .sweep_busy          (sweep_busy),
        .sweep_done          (sweep_done),
        .overrun             (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Lookup memory with one cycle of read latency; off-grid addresses return a marker value
    always @(posedge clk) begin
        if (view_x < GW && view_y < GH) begin
            view_signal <= sig_mem[int'(view_y) * GW + int'(view_x)];
            view_sugar  <= sug_mem[int'(view_y) * GW + int'(view_x)];
        end else begin
            view_signal <= 4'hA;
            view_sugar  <= 1'b1;
        end
    end

    function automatic int rel();
        return cyc - c0 + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, rel());
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] n, ne, e, se, s, sw, w, nw);
        return {nw, w, sw, s, se, e, ne, n};
    endfunction

    function automatic logic [31:0] model_win(input int x, input int y);
        int dx[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
        int dy[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
        logic [31:0] w = '0;
        for (int i = 0; i < 8; i++) begin
            int nx = x + dx[i];
            int ny = y + dy[i];
            if (nx >= 0 && nx < GW && ny >= 0 && ny < GH)
                w[i*4 +: 4] = sig_mem[ny * GW + nx];
        end
        return w;
    endfunction

    task automatic set_pattern(input int p);
        for (int i = 0; i < NC; i++) begin
            sig_mem[i] = (p == 0) ? 4'(i) : 4'hF;
            sug_mem[i] = (p == 0) ? ((i % GW) % 2 == 1) : 1'b1;
        end
    endtask

    task automatic push_sweep(input int extra_from, input int extra);
        wr_t r;
        exp_q.delete();
        for (int i = 0; i < NC; i++) begin
            r.x   = i % GW;
            r.y   = i / GW;
            r.cur = sig_mem[i];
            r.sug = sug_mem[i];
            r.win = model_win(r.x, r.y);
            r.at  = 11 * (i + 1) + ((i >= extra_from) ? extra : 0);
            exp_q.push_back(r);
        end
        exp_done_at = 11 * NC + extra + 1;
    endtask

    // Tick is raised just after a falling edge and sampled by the next rising edge (E0)
    task automatic start_sweep(input int extra_from, input int extra);
        #1;
        tick = 1'b1;
        c0   = cyc + 1;
        push_sweep(extra_from, extra);
        @(negedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic wait_rel(input int t);
        while (rel() < t) @(negedge clk);
    endtask

    // Scoreboard: every write_flag must match the next expected cell, at its expected cycle
    always @(negedge clk) begin : monitor
        wr_t r;
        if (rst_n && write_flag === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write_flag", 32'd1, 32'd0);
            end else begin
                r = exp_q.pop_front();
                check("wr_x", 32'(write_x), 32'(r.x));
                check("wr_y", 32'(write_y), 32'(r.y));
                check("wr_cur_signal", 32'(cur_signal), 32'(r.cur));
                check("wr_cur_sugar", 32'(cur_sugar), 32'(r.sug));
                check("wr_window", surr, r.win);
                check("wr_cycle", 32'(rel()), 32'(r.at));
                if (sweep_id < 2) begin
                    seen_cur[sweep_id][int'(write_y) * GW + int'(write_x)] = cur_signal;
                    seen_win[sweep_id][int'(write_y) * GW + int'(write_x)] = surr;
                end
            end
        end
        if (rst_n && sweep_done === 1'b1)
            check("sweep_done_cycle", 32'(rel()), 32'(exp_done_at));
    end

    initial begin
        vt[0] = '{0, 1, 1, 4'd5,  mk(4'd1, 4'd2, 4'd6, 4'd10, 4'd9, 4'd8, 4'd4, 4'd0)};
        vt[1] = '{0, 0, 0, 4'd0,  mk(4'd0, 4'd0, 4'd1, 4'd5, 4'd4, 4'd0, 4'd0, 4'd0)};
        vt[2] = '{0, 3, 2, 4'd11, mk(4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd10, 4'd6)};
        vt[3] = '{0, 3, 0, 4'd3,  mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd6, 4'd2, 4'd0)};
        vt[4] = '{1, 0, 0, 4'hF,  mk(4'd0, 4'd0, 4'hF, 4'hF, 4'hF, 4'd0, 4'd0, 4'd0)};
        vt[5] = '{1, 1, 1, 4'hF,  mk(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF)};
        vt[6] = '{1, 3, 2, 4'hF,  mk(4'hF, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'hF, 4'hF)};

        set_pattern(0);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_write_flag", 32'(write_flag), 32'd0);
        check("rst_busy", 32'(sweep_busy), 32'd0);
        check("rst_done", 32'(sweep_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_view_xy", {view_x, 1'b0, view_y}, 16'd0);
        check("rst_write_xy", {write_x, 1'b0, write_y}, 16'd0);
        check("rst_window", surr, 32'd0);
        check("rst_cur", {cur_signal, cur_sugar}, 5'd0);
        #1 rst_n = 1'b1;
        run = 1'b1;
        repeat (2) @(negedge clk);

        // Sweep A: plain sweep, signal = x + 4y
        sweep_id = 0;
        start_sweep(NC, 0);
        check("A_busy_cycle1", 32'(sweep_busy), 32'd1);
        check("A_no_flag_cycle1", 32'(write_flag), 32'd0);
        wait_rel(133);
        check("A_done_pulse", 32'(sweep_done), 32'd1);
        check("A_busy_after", 32'(sweep_busy), 32'd0);
        check("A_write_count", 32'(wr_cnt), 32'd12);

        // Sweep B: tick in the sweep_done cycle, PAUSE high cycles 20..60
        sweep_id = 2;
        start_sweep(2, 39);
        wait_rel(20);
        #1 pause = 1'b1;
        wait_rel(40);
        check("B_paused_x", 32'(write_x), 32'd2);
        check("B_paused_y", 32'(write_y), 32'd0);
        check("B_paused_flag", 32'(write_flag), 32'd0);
        check("B_paused_busy", 32'(sweep_busy), 32'd1);
        wait_rel(61);
        #1 pause = 1'b0;
        wait_rel(173);
        check("B_busy_after", 32'(sweep_busy), 32'd0);
        check("B_no_overrun", 32'(overrun), 32'd0);
        check("B_write_count", 32'(wr_cnt), 32'd24);

        // Sweep C: all-0xF memory, stray tick at cycle 50
        set_pattern(1);
        sweep_id = 1;
        repeat (2) @(negedge clk);
        start_sweep(NC, 0);
        wait_rel(50);
        #1 tick = 1'b1;
        @(negedge clk);
        #1 tick = 1'b0;
        wait_rel(52);
        check("C_overrun_set", 32'(overrun), 32'd1);
        wait_rel(134);
        check("C_overrun_sticky", 32'(overrun), 32'd1);
        check("C_write_count", 32'(wr_cnt), 32'd36);

        // Sweep D: RUN dropped at cycle 30
        set_pattern(0);
        sweep_id = 2;
        repeat (2) @(negedge clk);
        wr_mark = wr_cnt;
        start_sweep(NC, 0);
        wait_rel(30);
        #1 run = 1'b0;
        wait_rel(31);
        check("D_idle_busy", 32'(sweep_busy), 32'd0);
        check("D_writes_before_abort", 32'(wr_cnt - wr_mark), 32'd2);
        exp_q.delete();
        exp_done_at = -1;
        repeat (150) @(negedge clk);
        check("D_no_more_writes", 32'(wr_cnt - wr_mark), 32'd2);
        #1 run = 1'b1;

        // Sweep E: reset asserted mid-FETCH of the first cell
        set_pattern(1);
        repeat (2) @(negedge clk);
        wr_mark = wr_cnt;
        start_sweep(NC, 0);
        wait_rel(5);
        #1 rst_n = 1'b0;
        #1;
        check("E_rst_view_xy", {view_x, 1'b0, view_y}, 16'd0);
        check("E_rst_busy", 32'(sweep_busy), 32'd0);
        check("E_rst_overrun", 32'(overrun), 32'd0);
        check("E_rst_cur", 32'(cur_signal), 32'd0);
        check("E_rst_window", surr, 32'd0);
        exp_q.delete();
        exp_done_at = -1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("E_idle_after_reset", 32'(sweep_busy), 32'd0);
        check("E_no_writes", 32'(wr_cnt - wr_mark), 32'd0);

        for (int i = 0; i < 7; i++) begin
            check($sformatf("table%0d_cur", i), 32'(seen_cur[vt[i].sw][vt[i].y * GW + vt[i].x]), 32'(vt[i].cur));
            check($sformatf("table%0d_window", i), seen_win[vt[i].sw][vt[i].y * GW + vt[i].x], vt[i].win);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
